// File: rtl/mux_arb_n_if.sv
// Stream bundle for mux_arb_n: N_CH producer channels in, one registered stream out.
// slave is the arbiter's view; master is the producers and consumer around it.
interface mux_arb_n_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     mode_i;
  logic [N_CH*DATA_W-1:0]   in_data_i;
  logic [N_CH-1:0]          in_valid_i;
  logic [N_CH-1:0]          in_last_i;
  logic [N_CH-1:0]          in_ready_o;
  logic [DATA_W-1:0]        out_data_o;
  logic                     out_valid_o;
  logic                     out_last_o;
  logic [SEL_W-1:0]         out_sel_o;
  logic                     out_ready_i;

  modport slave (
    input  mode_i, in_data_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_last_o, out_sel_o
  );

  modport master (
    output mode_i, in_data_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_last_o, out_sel_o
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered arbitrating mux with fixed-priority or round-robin selection.
// Packets are atomic: a granted channel keeps the output until its last beat.
module mux_arb_n #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mux_arb_n_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam logic [SEL_W:0] NumChWide = (SEL_W+1)'(N_CH);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;

  logic              load;
  logic              found;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  start;
  logic [SEL_W:0]    idx_w;
  logic [N_CH-1:0]   grant;
  logic [DATA_W-1:0] cand_data;
  logic              accept;

  assign load = !out_valid_q || bus.out_ready_i;

  // Fixed priority is a rotating search that always starts at channel 0.
  always_comb begin
    start = bus.mode_i ? rr_ptr_q : '0;
    found = 1'b0;
    cand  = '0;
    idx_w = '0;
    if (state_q == StLocked) begin
      found = bus.in_valid_i[lock_ch_q];
      cand  = lock_ch_q;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx_w = {1'b0, start} + (SEL_W+1)'(k);
        if (idx_w >= NumChWide) idx_w = idx_w - NumChWide;
        if (!found && bus.in_valid_i[idx_w[SEL_W-1:0]]) begin
          found = 1'b1;
          cand  = idx_w[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cand == SEL_W'(c)) cand_data = bus.in_data_i[c*DATA_W +: DATA_W];
    end
  end

  assign grant          = found ? (N_CH'(1) << cand) : '0;
  assign accept         = load && found;
  assign bus.in_ready_o = (rst_ni && load) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_data_d  = cand_data;
      out_valid_d = 1'b1;
      out_last_d  = bus.in_last_i[cand];
      out_sel_d   = cand;
      if (bus.in_last_i[cand]) begin
        state_d  = StIdle;
        // Explicit wrap keeps the pointer legal for non-power-of-2 channel counts.
        rr_ptr_d = (cand == SEL_W'(N_CH-1)) ? '0 : cand + 1'b1;
      end else begin
        state_d   = StLocked;
        lock_ch_d = cand;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_data_o  = out_data_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.out_sel_o   = out_sel_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a 4-channel instance and a 3-channel instance
// share clock and reset; expected values are hand-computed constants.
module tb_mux_arb_n;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_arb_n_if #(.N_CH(4), .DATA_W(8)) bus_a ();
  mux_arb_n_if #(.N_CH(3), .DATA_W(8)) bus_b ();

  mux_arb_n #(.N_CH(4), .DATA_W(8)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  mux_arb_n #(.N_CH(3), .DATA_W(8)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_a.mode_i      = 1'b0;
    bus_a.out_ready_i = 1'b1;
    bus_a.in_valid_i  = 4'b1111;
    bus_a.in_last_i   = 4'b1111;
    bus_a.in_data_i   = 32'h13121110;
    bus_b.mode_i      = 1'b0;
    bus_b.out_ready_i = 1'b1;
    bus_b.in_valid_i  = 3'b000;
    bus_b.in_last_i   = 3'b111;
    bus_b.in_data_i   = 24'h0;

    // Reset held for 3 cycles with every channel valid
    repeat (3) tick();
    check_eq("rst_valid", 32'(bus_a.out_valid_o), 32'h0);
    check_eq("rst_data",  32'(bus_a.out_data_o),  32'h0);
    check_eq("rst_last",  32'(bus_a.out_last_o),  32'h0);
    check_eq("rst_sel",   32'(bus_a.out_sel_o),   32'h0);
    check_eq("rst_ready", 32'(bus_a.in_ready_o),  32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", 32'(bus_a.in_ready_o), 32'h1);
    tick();
    check_eq("rel_data",  32'(bus_a.out_data_o),  32'h10);
    check_eq("rel_sel",   32'(bus_a.out_sel_o),   32'h0);
    check_eq("rel_valid", 32'(bus_a.out_valid_o), 32'h1);

    // Fixed priority starves ch3 while ch1 stays valid
    bus_a.in_valid_i = 4'b1010;
    bus_a.in_data_i  = 32'h33001100;
    #1;
    check_eq("fp_ready", 32'(bus_a.in_ready_o), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fp_data", 32'(bus_a.out_data_o), 32'h11);
      check_eq("fp_sel",  32'(bus_a.out_sel_o),  32'h1);
    end
    bus_a.in_valid_i = 4'b0000;
    tick();
    check_eq("fp_drain", 32'(bus_a.out_valid_o), 32'h0);

    // Fresh reset so round-robin starts at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_a.mode_i     = 1'b1;
    bus_a.in_valid_i = 4'b1111;
    bus_a.in_data_i  = 32'hA3A2A1A0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rr_sel",  32'(bus_a.out_sel_o),  32'(i % 4));
      check_eq("rr_data", 32'(bus_a.out_data_o), 32'(8'hA0 + (i % 4)));
    end
    bus_a.in_valid_i = 4'b0000;
    tick();

    // Packet lock: rr_ptr is 1, so ch2 wins over ch0 and holds it for 3 beats
    bus_a.in_valid_i = 4'b0101;
    bus_a.in_last_i  = 4'b0001;
    bus_a.in_data_i  = 32'h00210005;
    tick();
    check_eq("lk_d1", 32'(bus_a.out_data_o), 32'h21);
    check_eq("lk_s1", 32'(bus_a.out_sel_o),  32'h2);
    check_eq("lk_l1", 32'(bus_a.out_last_o), 32'h0);
    check_eq("lk_ready", 32'(bus_a.in_ready_o), 32'h4);
    bus_a.in_data_i = 32'h00220005;
    tick();
    check_eq("lk_d2", 32'(bus_a.out_data_o), 32'h22);
    check_eq("lk_s2", 32'(bus_a.out_sel_o),  32'h2);
    bus_a.in_data_i = 32'h00230005;
    bus_a.in_last_i = 4'b0101;
    tick();
    check_eq("lk_d3", 32'(bus_a.out_data_o), 32'h23);
    check_eq("lk_l3", 32'(bus_a.out_last_o), 32'h1);
    check_eq("lk_rr", 32'(dut_a.rr_ptr_q),   32'h3);
    bus_a.in_valid_i = 4'b0001;
    tick();
    check_eq("lk_next_d", 32'(bus_a.out_data_o), 32'h05);
    check_eq("lk_next_s", 32'(bus_a.out_sel_o),  32'h0);

    // Backpressure with 0x55 pending, 0x66 queued behind it
    bus_a.mode_i     = 1'b0;
    bus_a.in_valid_i = 4'b0010;
    bus_a.in_last_i  = 4'b0010;
    bus_a.in_data_i  = 32'h00005500;
    tick();
    check_eq("bp_first", 32'(bus_a.out_data_o), 32'h55);
    bus_a.out_ready_i = 1'b0;
    bus_a.in_data_i   = 32'h00006600;
    #1;
    check_eq("bp_ready0", 32'(bus_a.in_ready_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_valid", 32'(bus_a.out_valid_o), 32'h1);
      check_eq("bp_data",  32'(bus_a.out_data_o),  32'h55);
      check_eq("bp_ready", 32'(bus_a.in_ready_o),  32'h0);
    end
    bus_a.out_ready_i = 1'b1;
    #1;
    check_eq("bp_rel_ready", 32'(bus_a.in_ready_o), 32'h2);
    tick();
    check_eq("bp_next_d", 32'(bus_a.out_data_o),  32'h66);
    check_eq("bp_next_v", 32'(bus_a.out_valid_o), 32'h1);
    bus_a.in_valid_i = 4'b0000;
    tick();
    check_eq("bp_drain", 32'(bus_a.out_valid_o), 32'h0);

    // 3-channel instance: pointer wrap 2 -> 0, then mode switch mid-packet
    bus_b.mode_i     = 1'b1;
    bus_b.in_data_i  = 24'h323130;
    bus_b.in_valid_i = 3'b010;
    tick();
    check_eq("n3_s1", 32'(bus_b.out_sel_o), 32'h1);
    bus_b.in_valid_i = 3'b100;
    tick();
    check_eq("n3_s2",   32'(bus_b.out_sel_o), 32'h2);
    check_eq("n3_wrap", 32'(dut_b.rr_ptr_q),  32'h0);
    bus_b.in_valid_i = 3'b111;
    tick();
    check_eq("n3_s0", 32'(bus_b.out_sel_o),  32'h0);
    check_eq("n3_d0", 32'(bus_b.out_data_o), 32'h30);
    bus_b.in_valid_i = 3'b011;
    bus_b.in_last_i  = 3'b001;
    bus_b.in_data_i  = 24'h324140;
    tick();
    check_eq("n3_lk_d", 32'(bus_b.out_data_o), 32'h41);
    check_eq("n3_lk_s", 32'(bus_b.out_sel_o),  32'h1);
    bus_b.mode_i    = 1'b0;
    bus_b.in_data_i = 24'h324240;
    bus_b.in_last_i = 3'b011;
    #1;
    check_eq("n3_lk_ready", 32'(bus_b.in_ready_o), 32'h2);
    tick();
    check_eq("n3_end_d", 32'(bus_b.out_data_o), 32'h42);
    check_eq("n3_end_s", 32'(bus_b.out_sel_o),  32'h1);
    check_eq("n3_rr",    32'(dut_b.rr_ptr_q),   32'h2);
    bus_b.in_valid_i = 3'b101;
    bus_b.in_last_i  = 3'b111;
    #1;
    check_eq("n3_fp_ready", 32'(bus_b.in_ready_o), 32'h1);
    tick();
    check_eq("n3_fp_s", 32'(bus_b.out_sel_o),  32'h0);
    check_eq("n3_fp_d", 32'(bus_b.out_data_o), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-channel registered arbitrating multiplexer, the successor of the team's 2:1 mux. Selects one of `N_CH` valid/ready input streams, using fixed-priority or round-robin arbitration, and forwards it through one output register stage. Packets are atomic: once a channel is granted, it holds the output until its last beat. The block sits between multiple producers and a single downstream consumer.

## Interface
- `N_CH`, 4, number of input channels; legal range is 2 and up, and non-power-of-2 values are legal.
- `DATA_W`, 8, data width per channel.
- `SEL_W`, `$clog2(N_CH)`, derived local parameter; width of the channel index.

- `clk_i`  input  1  single clock; all logic is on its rising edge.
- `rst_ni`  input  1  reset; synchronous, active-low.
- `mode_i`  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `in_data_i`  input  N_CH*DATA_W  channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `in_valid_i`  input  N_CH  per-channel valid.
- `in_last_i`  input  N_CH  per-channel last-beat-of-packet flag.
- `in_ready_o`  output  N_CH  per-channel ready; one-hot or zero.
- `out_data_o`  output  DATA_W  registered data.
- `out_valid_o`  output  1  registered valid.
- `out_last_o`  output  1  registered last flag.
- `out_sel_o`  output  SEL_W  index of the channel that produced the current output beat.
- `out_ready_i`  input  1  downstream ready.

## Operation
- `load = !out_valid_o || out_ready_i`. The output register can take a new beat this cycle.
- **State machine `IDLE` / `LOCKED`:**
  - `lock_ch` (SEL_W) holds the locked channel.
  - `rr_ptr` (SEL_W) is the round-robin start index.
- **Candidate selection (combinational):**
  - `IDLE`, `mode_i`=0: lowest index c with `in_valid_i[c]`.
  - `IDLE`, `mode_i`=1: first valid c searching `rr_ptr`, `rr_ptr+1`, … modulo `N_CH`.
  - `LOCKED`: only `lock_ch`, and only if `in_valid_i[lock_ch]` is high. All other channels are stalled even if valid.
  - No candidate means no grant.
- `in_ready_o[c] = load && grant[c]`. An accept occurs when `in_valid_i[c] && in_ready_o[c]`.
- **On accept of channel g:**
  - The output register captures `out_data_o`, `out_last_o` and `out_sel_o` from channel g, and sets `out_valid_o` to 1.
  - If `in_last_i[g]` is 0: state goes to `LOCKED` with `lock_ch` = g.
  - If `in_last_i[g]` is 1: state goes to `IDLE`, and `rr_ptr` becomes `(g+1) mod N_CH`.
  - `rr_ptr` updates only at packet end, and updates in both modes.
- **On load without accept:** `out_valid_o` goes to 0; data, last and sel are held.
- **When `load` is 0:** all output registers hold, and all `in_ready_o` are 0.
- **Mode changes:** `mode_i` is consulted only in `IDLE`. A change during `LOCKED` takes effect at the first arbitration after the packet ends.
- **Single-beat packets** (last=1 on the first beat) never enter `LOCKED`.
- **Wrap-around:** `rr_ptr` = N_CH-1 wraps to 0. The modulo is explicit, and this must be correct for non-power-of-2 `N_CH`.

## Timing
- **Reset** (`rst_ni`=0 at a clock edge):
  - `out_valid_o` = 0, `out_data_o` = 0, `out_last_o` = 0, `out_sel_o` = 0.
  - State = `IDLE`, `rr_ptr` = 0, `lock_ch` = 0.
  - `in_ready_o` is forced to all zeros while `rst_ni` is low.
- **Reset mid-packet:** the lock is dropped and the in-flight output beat is discarded. There is no recovery of the partial packet.
- **Latency:** 1 cycle. A beat accepted at edge k appears on the outputs after edge k.
- **Throughput:** one beat per cycle when `out_ready_i` is held at 1.
- `in_ready_o` is combinational from `in_valid_i`, `out_ready_i`, state and `mode_i`; there is no combinational path from `in_data_i` to any output.
- **Handshakes follow AXI-stream style rules:**
  - `out_valid_o` is held with stable data until `out_ready_i`.
  - Producers must not drop valid or change data before accept.
- **Simultaneous events** (output beat consumed and new beat accepted in the same cycle): the register is overwritten with no bubble.

## Test plan
1. **Reset:** hold `rst_ni`=0 for 3 cycles with all `in_valid_i`=4'b1111. Required: all outputs 0 and `in_ready_o`=0; on release, channel 0 is accepted first.
2. **Fixed priority, single-beat packets:** `mode_i`=0, `out_ready_i`=1, valid on ch1 (0x11) and ch3 (0x33), last=1. Required: 0x11 is output with sel=1 each cycle while ch1 stays valid, and ch3 is starved.
3. **Round-robin rotation:** `mode_i`=1, all 4 channels valid with data 0xA0+c, last=1. Required: output sequence sel 0,1,2,3,0 on consecutive cycles, with data 0xA0,0xA1,0xA2,0xA3,0xA0.
4. **Packet lock:** `mode_i`=1, ch2 sends a 3-beat packet 0x21,0x22,0x23 (last on the 3rd beat) while ch0 is valid throughout. Required: ch2's three beats are output contiguously with sel=2, then ch0 follows; `rr_ptr` = 3 after the packet.
5. **Backpressure:** hold `out_ready_i`=0 for 4 cycles while beat 0x55 is pending. Required: `out_valid_o`=1 and `out_data_o`=0x55 are stable, all `in_ready_o`=0; when `out_ready_i` goes to 1, the next beat follows in the following cycle with no bubble.
6. **Non-power-of-2 and mode switch mid-packet:** with `N_CH`=3, `rr_ptr` wraps 2→0. Toggling `mode_i` from 1 to 0 during a locked packet must not break the lock; fixed priority applies from the next packet.
